// File: rtl/instr_prefetch_buffer_if.sv
// Bus bundle for the instruction prefetch buffer: CPU fetch port plus
// instruction-memory request/ack port. slave = buffer side, master = environment.
interface instr_prefetch_buffer_if;
    logic [31:0] cpu_pc;
    logic        cpu_fetch_en;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_pc, cpu_fetch_en, mem_ack, mem_rdata,
        output cpu_instr, cpu_stall, mem_req, mem_addr
    );

    modport master (
        output cpu_pc, cpu_fetch_en, mem_ack, mem_rdata,
        input  cpu_instr, cpu_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetch FIFO with single outstanding memory request.
// Optional macro PREFETCH_STATS_EN adds saturating redirect/stall counters.
module instr_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_prefetch_buffer_if.slave   bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]              stat_redirects,
    output logic [15:0]              stat_stalls
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_reg, state_next;
    logic          mem_req_reg, mem_req_next;
    logic [31:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]   next_addr_reg, next_addr_next;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] head_reg, tail_reg;
    logic [AW:0]   count_reg, count_next;

    logic          fifo_nonempty, fifo_space;
    logic [31:0]   head_addr, head_data, expected_addr;
    logic          hit, redirect, push, pop;

    // Head is read combinationally so a hit serves the CPU in the same cycle.
    assign head_addr     = addr_mem[head_reg];
    assign head_data     = data_mem[head_reg];
    assign fifo_nonempty = (count_reg != '0);
    assign fifo_space    = (count_reg < DEPTH_C);
    assign hit           = fifo_nonempty && (head_addr == bus.cpu_pc);

    always_comb begin
        expected_addr = next_addr_reg;
        if (fifo_nonempty)
            expected_addr = head_addr;
        else if (state_reg == WAIT)
            expected_addr = mem_addr_reg;
    end

    assign redirect = (bus.cpu_pc != expected_addr);
    assign pop      = hit && bus.cpu_fetch_en && !redirect;
    assign push     = (state_reg == WAIT) && bus.mem_ack && !redirect;

    assign bus.cpu_stall = ~hit;
    assign bus.cpu_instr = hit ? head_data : 32'h0000_0000;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_addr  = mem_addr_reg;

    always_comb begin
        count_next = count_reg;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + (AW + 1)'(1);
        else if (pop && !push)
            count_next = count_reg - (AW + 1)'(1);
    end

    // Storage carries no reset; only entries counted by count_reg are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= mem_addr_reg;
            data_mem[tail_reg] <= bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (redirect) begin
                head_reg <= '0;
                tail_reg <= '0;
            end else begin
                if (pop)
                    head_reg <= head_reg + AW'(1);
                if (push)
                    tail_reg <= tail_reg + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= 32'h0000_0000;
            next_addr_reg <= RESET_PC;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            next_addr_reg <= next_addr_next;
        end
    end

    // A request once issued is held until acked; DROP swallows the stale reply.
    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_addr_next  = mem_addr_reg;
        next_addr_next = redirect ? bus.cpu_pc : next_addr_reg;
        case (state_reg)
            IDLE: begin
                if (!redirect && fifo_space) begin
                    mem_req_next   = 1'b1;
                    mem_addr_next  = next_addr_reg;
                    next_addr_next = next_addr_reg + 32'd4;
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.mem_ack) begin
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_redirects <= 16'h0000;
            stat_stalls    <= 16'h0000;
        end else begin
            if (redirect && (stat_redirects != 16'hFFFF))
                stat_redirects <= stat_redirects + 16'd1;
            if (bus.cpu_stall && bus.cpu_fetch_en && (stat_stalls != 16'hFFFF))
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Instruction-fetch front end between the pipelined CPU's pc/instr ports and a multi-cycle instruction memory.
- Prefetches sequential words into a small FIFO.
- Serves the CPU combinationally on an address hit and stalls it on a miss.
- Flushes and redirects when the CPU pc departs from the sequential stream (branch, j, jal, jr).

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
cpu_pc  in  32  current IF-stage pc
cpu_fetch_en  in  1  CPU latches cpu_instr this cycle (IF/ID enable)
cpu_instr  out  32  instruction for cpu_pc; 32'h00000000 (nop) on miss
cpu_stall  out  1  1 = cpu_instr not valid for cpu_pc
mem_req  out  1  registered request to instruction memory
mem_addr  out  32  registered word address, stable while mem_req=1
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  32  instruction word

Behaviour:
- FIFO entries are {addr[31:0], data[31:0]}; count 0..DEPTH; pointers wrap mod DEPTH.
- Registers: next_addr, which is the address of the next request.
- Reset values: FIFO empty, next_addr = RESET_PC, state IDLE, mem_req = 0, mem_addr = 0, cpu_stall = 1, cpu_instr = 0.
- Hit: count != 0 and head.addr == cpu_pc.
  - cpu_stall = ~hit.
  - cpu_instr = hit ? head.data : 0 (combinational).
- Pop: hit & cpu_fetch_en pops the head at the clock edge.
- Expected address:
  - head.addr if count != 0;
  - else mem_addr in WAIT;
  - else next_addr in IDLE/DROP.
- Redirect: cpu_pc != expected address.
  - FIFO flushed (count <= 0).
  - next_addr <= cpu_pc.
  - Redirect overrides pop and push in the same cycle.
- State machine:
  - IDLE: if no redirect and count < DEPTH, then mem_req <= 1, mem_addr <= next_addr, next_addr <= next_addr + 4 (32-bit wrap, 32'hFFFFFFFC -> 0); go to WAIT.
  - WAIT: mem_req and mem_addr held until mem_ack.
    - ack without redirect: push {mem_addr, mem_rdata}; mem_req <= 0; go to IDLE.
    - redirect without ack: go to DROP.
    - ack with redirect in the same cycle: data discarded; go to IDLE.
  - DROP: mem_req held (a request is never withdrawn).
    - On mem_ack: data discarded; mem_req <= 0; go to IDLE.
    - A further redirect in DROP only updates next_addr.
- Push and pop may occur in the same cycle, including at count == DEPTH-1; count is unchanged.
- A push into a full FIFO cannot occur, because issue requires count < DEPTH and only one request is ever in flight.
- mem_ack outside WAIT/DROP is ignored.
- Miss latency with a zero-wait memory (ack in the req cycle):
  - redirect edge at t;
  - mem_req high during t+1;
  - entry written at end of t+1;
  - cpu_stall = 0 during t+2.
- Steady-state sequential throughput with zero-wait memory: one word per 2 cycles.
- Reset asserted mid-transaction aborts immediately to reset values. The memory is required to be reset in the same domain.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined, adds outputs stat_redirects[15:0] (increments on each redirect) and stat_stalls[15:0] (increments each cycle with cpu_stall & cpu_fetch_en).
  - Both saturate at 16'hFFFF.
  - Both reset to 0.
- When undefined, neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset release, cpu_pc=0, cpu_fetch_en=1, zero-wait memory returning addr-based words → mem_req at cycle 1 with mem_addr=0; cpu_instr=word(0), cpu_stall=0 at cycle 2; sequential pcs 4, 8, 12 all hit.
- Fill with cpu_fetch_en=0, cpu_pc=0 → requests for 0, 4, 8, 12 complete; then mem_req stays 0 with count=4; raising cpu_fetch_en pops one per cycle while cpu_pc steps.
- With head.addr=0x10, set cpu_pc=0x40 (branch) → flush, cpu_stall=1, next request mem_addr=0x40, hit 2 cycles later.
- 3-cycle-latency memory, redirect to 0x80 while the request for 0x20 is outstanding → state DROP, mem_addr held at 0x20 until ack, 0x20 data discarded, next mem_addr=0x80.
- next_addr=0xFFFFFFFC → requests issue 0xFFFFFFFC then 0x00000000; assert reset low during WAIT → mem_req=0, cpu_stall=1 immediately.
- PREFETCH_STATS_EN defined, 3 redirects plus 5 stalled fetch cycles → stat_redirects=3, stat_stalls=5.
